program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host pin / RAM write bus between the host side and the program loader.
interface program_loader_if #(parameter int ADDR_W = 4);
  logic              load_en;
  logic              strobe;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              byte_ack;
  logic              cpu_run;
  logic              done;
  logic              err;

  modport master (
    output load_en, strobe, data_in,
    input  ram_addr, ram_data, ram_we, byte_ack, cpu_run, done, err
  );

  modport slave (
    input  load_en, strobe, data_in,
    output ram_addr, ram_data, ram_we, byte_ack, cpu_run, done, err
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-serial program loader writing 2**ADDR_W words to RAM, then releasing the CPU.
// LOADER_CHECKSUM_EN adds a trailing checksum byte with CHECK/ERROR states.
module program_loader #(
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, CHECK, RUN, ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nxt;
  logic              sync1, sync2, sync_prev;
  logic              byte_evt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        data_q;
  logic              done_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic [7:0]        chk_total;
  assign chk_total = sum_q + bus.data_in;
`endif

  // Third flop gives the rising edge of the synchronized strobe, one pulse per host byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= bus.strobe;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign byte_evt = sync2 & ~sync_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = bus.load_en ? WAIT_BYTE : RUN;
      WAIT_BYTE: begin
        if (!bus.load_en)  state_nxt = RUN;
        else if (byte_evt) state_nxt = WRITE;
      end
      WRITE: begin
        if (addr_q != LAST_ADDR) state_nxt = WAIT_BYTE;
`ifdef LOADER_CHECKSUM_EN
        else                     state_nxt = CHECK;
`else
        else                     state_nxt = RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (!bus.load_en)  state_nxt = RUN;
        else if (byte_evt) state_nxt = (chk_total == 8'd0) ? RUN : ERROR;
      end
`endif
      RUN, ERROR: state_nxt = state;
      default:    state_nxt = IDLE;
    endcase
  end

  // wr_ptr is the next free word; ram_addr keeps the most recently written one, so an abort leaves it there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      wr_ptr <= '0;
      data_q <= 8'd0;
      done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          addr_q <= '0;
          wr_ptr <= '0;
        end
        WAIT_BYTE: begin
          if (bus.load_en && byte_evt) begin
            data_q <= bus.data_in;
            addr_q <= wr_ptr;
          end
        end
        WRITE: begin
`ifdef LOADER_CHECKSUM_EN
          sum_q <= sum_q + data_q;
`endif
          if (addr_q != LAST_ADDR) wr_ptr <= wr_ptr + 1'b1;
`ifndef LOADER_CHECKSUM_EN
          else                     done_q <= 1'b1;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.load_en && byte_evt && chk_total == 8'd0) done_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_we   = (state == WRITE);
  assign bus.byte_ack = (state == WRITE);
  assign bus.cpu_run  = (state == RUN);
  assign bus.done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.err      = (state == ERROR);
`else
  assign bus.err      = 1'b0;
`endif

endmodule
